cga_vram_sequencer: RTL

Free-running character-cell sequencer and VRAM arbiter for the CGA display path. It generates `clk_seq` and the `vram_read_char`, `vram_read_att`, `charrom_read` and `disp_pipeline` strobes that drive `cga_pixel`. It also time-multiplexes the single-port 16 KB VRAM between display fetches and CPU accesses at fixed slots. It sits between the CRTC (address source), the bus interface (CPU requester), the VRAM and `cga_pixel`.

---
 rtl/cga_seq_pkg.sv | 26 ++
 rtl/cga_cpu_window.sv | 64 ++++++
 rtl/cga_vram_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cga_seq_pkg.sv
// Shared slot offsets, CPU-port state encoding and slot-offset helper for the
// CGA VRAM sequencer.
package cga_seq_pkg;

    // Offsets within a character slot
    localparam logic [4:0] SEQ_SLOT0     = 5'd0;   // char address driven
    localparam logic [4:0] SEQ_CHAR      = 5'd1;   // char byte on the bus, attr address driven
    localparam logic [4:0] SEQ_ATT       = 5'd2;
    localparam logic [4:0] SEQ_ROM       = 5'd3;
    localparam logic [4:0] SEQ_CPU0      = 5'd4;
    localparam logic [4:0] SEQ_CPU1      = 5'd20;  // lores only
    localparam logic [4:0] SEQ_LAST_HRES = 5'd15;
    localparam logic [4:0] SEQ_LAST_LRES = 5'd31;

    // CPU port states
    typedef logic [1:0] cpu_state_t;
    localparam cpu_state_t CpuIdle   = 2'd0;
    localparam cpu_state_t CpuAccess = 2'd1;
    localparam cpu_state_t CpuAck    = 2'd2;

    // Hres slots are 16 clocks long, so only the low nibble is significant
    function automatic logic [4:0] slot_offset(input logic hres, input logic [4:0] seq);
        return hres ? {1'b0, seq[3:0]} : seq;
    endfunction

endpackage

// File: rtl/cga_cpu_window.sv
// CPU access port of the VRAM arbiter: grant qualification, IDLE/ACCESS/ACK
// sequencing and read-data capture.
module cga_cpu_window
    import cga_seq_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       win_i,
    input  logic       cpu_req_i,
    input  logic       cpu_we_i,
    input  logic [7:0] ram_rdata_i,
    output logic       grant_o,
    output logic       cpu_ack_o,
    output logic [7:0] cpu_rdata_o
);

    cpu_state_t state_q, state_d;
    logic       we_q, we_d;
    logic [7:0] rdata_q, rdata_d;

    // Only an idle port may take a window; a request arriving late waits
    assign grant_o = win_i && cpu_req_i && (state_q == CpuIdle);

    // Port sequencing and read-data capture on the ack clock
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        case (state_q)
            CpuIdle: begin
                if (grant_o) begin
                    state_d = CpuAccess;
                    we_d    = cpu_we_i;
                end
            end
            CpuAccess: state_d = CpuAck;
            CpuAck: begin
                state_d = CpuIdle;
                if (!we_q) begin
                    rdata_d = ram_rdata_i;
                end
            end
            default: state_d = CpuIdle;
        endcase
    end

    // State registers; reset abandons any access without an ack
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= CpuIdle;
            we_q    <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    assign cpu_ack_o = (state_q == CpuAck);
    // VRAM data arrives in the ack cycle itself, so forward it then and hold after
    assign cpu_rdata_o = (cpu_ack_o && !we_q) ? ram_rdata_i : rdata_q;

endmodule

// File: rtl/cga_vram_sequencer.sv
// CGA character-cell sequencer and single-port VRAM arbiter. Generates the
// cga_pixel strobes and interleaves CPU accesses into fixed slot positions.
// Optional build macro CGA_SNOW_EN adds a CPU window at slot offset 0 in hres
// text mode, displacing the char fetch (IBM "snow").
module cga_vram_sequencer
    import cga_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              hres_mode_i,
    input  logic              grph_mode_i,
    input  logic [12:0]       crtc_ma_i,
    input  logic              crtc_ra0_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]        cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [7:0]        cpu_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_wdata_o,
    input  logic [7:0]        ram_rdata_i,
    output logic [7:0]        vram_data_o,
    output logic [4:0]        clk_seq_o,
    output logic              vram_read_char_o,
    output logic              vram_read_att_o,
    output logic              charrom_read_o,
    output logic              disp_pipeline_o,
    output logic              crtc_clk_en_o
);

    logic [4:0]        seq_q, seq_d, s_next, s_last;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              read_char_q, read_att_q, rom_read_q, last_q;
    logic [13:0]       char_addr, attr_addr;
    logic              snow_win, win, grant;

    // Outputs are registered, so decode against the offset of the coming cycle
    assign seq_d  = seq_q + 5'd1;
    assign s_next = slot_offset(hres_mode_i, seq_d);
    assign s_last = hres_mode_i ? SEQ_LAST_HRES : SEQ_LAST_LRES;

    // Display fetch addresses; attribute byte always follows its character
    always_comb begin
        if (grph_mode_i) begin
            char_addr = {crtc_ra0_i, crtc_ma_i[11:0], 1'b0};
        end else begin
            char_addr = {crtc_ma_i, 1'b0};
        end
        attr_addr = char_addr | 14'd1;
    end

`ifdef CGA_SNOW_EN
    assign snow_win = hres_mode_i && !grph_mode_i && (s_next == SEQ_SLOT0);
`else
    assign snow_win = 1'b0;
`endif

    assign win = (s_next == SEQ_CPU0) || (!hres_mode_i && (s_next == SEQ_CPU1)) || snow_win;

    cga_cpu_window u_cpu_window (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .win_i       (win),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .ram_rdata_i (ram_rdata_i),
        .grant_o     (grant),
        .cpu_ack_o   (cpu_ack_o),
        .cpu_rdata_o (cpu_rdata_o)
    );

    // VRAM bus mux: a granted CPU access wins over the display address
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        if (grant) begin
            ram_addr_d  = cpu_addr_i;
            ram_we_d    = cpu_we_i;
            ram_wdata_d = cpu_wdata_i;
        end else if (s_next == SEQ_SLOT0) begin
            ram_addr_d = ADDR_W'(char_addr);
        end else if (s_next == SEQ_CHAR) begin
            ram_addr_d = ADDR_W'(attr_addr);
        end
    end

    // Counter, VRAM bus and strobe registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            seq_q       <= 5'd0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 8'h00;
            ram_we_q    <= 1'b0;
            read_char_q <= 1'b0;
            read_att_q  <= 1'b0;
            rom_read_q  <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            seq_q       <= seq_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            read_char_q <= (s_next == SEQ_CHAR);
            read_att_q  <= (s_next == SEQ_ATT);
            rom_read_q  <= (s_next == SEQ_ROM);
            last_q      <= (s_next == s_last);
        end
    end

    assign clk_seq_o        = seq_q;
    assign ram_addr_o       = ram_addr_q;
    assign ram_we_o         = ram_we_q;
    assign ram_wdata_o      = ram_wdata_q;
    assign vram_data_o      = ram_rdata_i;
    assign vram_read_char_o = read_char_q;
    assign vram_read_att_o  = read_att_q;
    assign charrom_read_o   = rom_read_q;
    assign disp_pipeline_o  = last_q;
    assign crtc_clk_en_o    = last_q;

endmodule
